// File: rtl/program_counter_ext.sv
// Program counter with PDP-8 style memory-extension field registers (IF/IB/SF).
// Drives the extended address {IF,PC} to the memory-address multiplexer.
module program_counter_ext #(
  parameter int              WIDTH       = 12,
  parameter int              FIELD_W     = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic [WIDTH-1:0]         IN,
  input  logic                     LD,
  input  logic                     SKIP,
  input  logic                     INC,
  input  logic                     LATCH,
  input  logic [FIELD_W-1:0]       FIELD_IN,
  input  logic                     LDIB,
  input  logic                     JMP,
  input  logic                     INTR,
  input  logic                     RESTORE,
  output logic [WIDTH-1:0]         PC,
  output logic [WIDTH-1:0]         PCLAT,
  output logic [FIELD_W-1:0]       IF,
  output logic [FIELD_W-1:0]       IB,
  output logic [FIELD_W-1:0]       SF,
  output logic [FIELD_W+WIDTH-1:0] ADDR,
  output logic                     WRAP
);

  logic [WIDTH:0]       stepVal;
  logic [WIDTH:0]       addSum;
  logic [WIDTH-1:0]     pcNext;
  logic                 wrapNext;
  logic [WIDTH-1:0]     pclatNext;
  logic [FIELD_W-1:0]   ifNext;
  logic [FIELD_W-1:0]   ibNext;
  logic [FIELD_W-1:0]   sfNext;

  // One extra bit on the adder so the carry-out becomes the WRAP flag.
  assign stepVal = SKIP ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
  assign addSum  = {1'b0, PC} + stepVal;

  always_comb begin
    pcNext   = PC;
    wrapNext = 1'b0;
    if (LD) begin
      pcNext = IN;
    end else if (SKIP || INC) begin
      pcNext   = addSum[WIDTH-1:0];
      wrapNext = addSum[WIDTH];
    end
  end

  assign pclatNext = LATCH ? PC : PCLAT;

  // Interrupt entry pre-empts all other field traffic; otherwise a jump moves the
  // old IB into IF while LDIB/RESTORE may reload IB on the same edge.
  always_comb begin
    ifNext = IF;
    ibNext = IB;
    sfNext = SF;
    if (INTR) begin
      sfNext = IF;
      ifNext = '0;
      ibNext = '0;
    end else begin
      if (LD && JMP) begin
        ifNext = IB;
      end
      if (LDIB) begin
        ibNext = FIELD_IN;
      end else if (RESTORE) begin
        ibNext = SF;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      PC    <= RESET_VALUE;
      PCLAT <= '0;
      IF    <= '0;
      IB    <= '0;
      SF    <= '0;
      WRAP  <= 1'b0;
    end else begin
      PC    <= pcNext;
      PCLAT <= pclatNext;
      IF    <= ifNext;
      IB    <= ibNext;
      SF    <= sfNext;
      WRAP  <= wrapNext;
    end
  end

  assign ADDR = {IF, PC};

endmodule

// File: tb/tb_program_counter_ext.sv
// Directed self-checking bench for program_counter_ext: a default 12-bit
// instance and a WIDTH=15 / FIELD_W=2 instance with a non-zero reset value.
module tb_program_counter_ext;

  localparam logic [9:0] kClr     = 10'h001;
  localparam logic [9:0] kLd      = 10'h002;
  localparam logic [9:0] kSkip    = 10'h004;
  localparam logic [9:0] kInc     = 10'h008;
  localparam logic [9:0] kLatch   = 10'h010;
  localparam logic [9:0] kLdib    = 10'h020;
  localparam logic [9:0] kJmp     = 10'h040;
  localparam logic [9:0] kIntr    = 10'h080;
  localparam logic [9:0] kRestore = 10'h100;
  localparam logic [9:0] kIdle    = 10'h000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int errorCount = 0;
  int checkCount = 0;

  logic [9:0]  ctrlA = '0;
  logic [11:0] inA = '0;
  logic [2:0]  fieldA = '0;
  logic [11:0] pcA, pclatA;
  logic [2:0]  ifA, ibA, sfA;
  logic [14:0] addrA;
  logic        wrapA;

  logic [9:0]  ctrlB = '0;
  logic [14:0] inB = '0;
  logic [1:0]  fieldB = '0;
  logic [14:0] pcB, pclatB;
  logic [1:0]  ifB, ibB, sfB;
  logic [16:0] addrB;
  logic        wrapB;

  int wrapPulses;

  program_counter_ext dutA (
    .CLK(clock), .CLR(ctrlA[0]), .IN(inA), .LD(ctrlA[1]), .SKIP(ctrlA[2]),
    .INC(ctrlA[3]), .LATCH(ctrlA[4]), .FIELD_IN(fieldA), .LDIB(ctrlA[5]),
    .JMP(ctrlA[6]), .INTR(ctrlA[7]), .RESTORE(ctrlA[8]),
    .PC(pcA), .PCLAT(pclatA), .IF(ifA), .IB(ibA), .SF(sfA), .ADDR(addrA), .WRAP(wrapA)
  );

  program_counter_ext #(.WIDTH(15), .FIELD_W(2), .RESET_VALUE(15'h7FF0)) dutB (
    .CLK(clock), .CLR(ctrlB[0]), .IN(inB), .LD(ctrlB[1]), .SKIP(ctrlB[2]),
    .INC(ctrlB[3]), .LATCH(ctrlB[4]), .FIELD_IN(fieldB), .LDIB(ctrlB[5]),
    .JMP(ctrlB[6]), .INTR(ctrlB[7]), .RESTORE(ctrlB[8]),
    .PC(pcB), .PCLAT(pclatB), .IF(ifB), .IB(ibB), .SF(sfB), .ADDR(addrB), .WRAP(wrapB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one edge's worth of controls, then release them and settle past the edge.
  task automatic applyStimulus(input logic [9:0] ctrl, input logic [11:0] inVal,
                               input logic [2:0] fieldVal);
    ctrlA  = ctrl;
    inA    = inVal;
    fieldA = fieldVal;
    @(posedge clock);
    #1;
    ctrlA = kIdle;
  endtask

  task automatic applyStimulusB(input logic [9:0] ctrl, input logic [14:0] inVal,
                                input logic [1:0] fieldVal);
    ctrlB  = ctrl;
    inB    = inVal;
    fieldB = fieldVal;
    @(posedge clock);
    #1;
    ctrlB = kIdle;
  endtask

  initial begin
    @(negedge clock);

    // Reset, load, increment, skip
    applyStimulus(kClr, 12'h000, 3'd0);
    checkOutput("rst_pc", 32'(pcA), 32'h000);
    checkOutput("rst_pclat", 32'(pclatA), 32'h000);
    checkOutput("rst_fields", {23'd0, ifA, ibA, sfA}, 32'h0);
    checkOutput("rst_wrap", 32'(wrapA), 32'h0);
    applyStimulus(kLd, 12'h123, 3'd0);
    checkOutput("ld_pc", 32'(pcA), 32'h123);
    for (int i = 0; i < 3; i++) applyStimulus(kInc, 12'h000, 3'd0);
    checkOutput("inc3_pc", 32'(pcA), 32'h126);
    applyStimulus(kSkip, 12'h000, 3'd0);
    checkOutput("skip_pc", 32'(pcA), 32'h128);
    checkOutput("skip_addr", 32'(addrA), 32'h0128);

    // Wrap behaviour
    applyStimulus(kLd, 12'hFFE, 3'd0);
    applyStimulus(kInc, 12'h000, 3'd0);
    checkOutput("inc_fff_pc", 32'(pcA), 32'hFFF);
    checkOutput("inc_fff_wrap", 32'(wrapA), 32'h0);
    applyStimulus(kInc, 12'h000, 3'd0);
    checkOutput("inc_wrap_pc", 32'(pcA), 32'h000);
    checkOutput("inc_wrap_flag", 32'(wrapA), 32'h1);
    applyStimulus(kIdle, 12'h000, 3'd0);
    checkOutput("wrap_drop", 32'(wrapA), 32'h0);
    checkOutput("hold_pc", 32'(pcA), 32'h000);
    applyStimulus(kLd, 12'hFFF, 3'd0);
    applyStimulus(kSkip, 12'h000, 3'd0);
    checkOutput("skip_wrap_pc", 32'(pcA), 32'h001);
    checkOutput("skip_wrap_flag", 32'(wrapA), 32'h1);
    applyStimulus(kLd, 12'hFFE, 3'd0);
    checkOutput("ld_clears_wrap", 32'(wrapA), 32'h0);
    applyStimulus(kSkip, 12'h000, 3'd0);
    checkOutput("skip_ffe_pc", 32'(pcA), 32'h000);
    checkOutput("skip_ffe_wrap", 32'(wrapA), 32'h1);

    // Priority and latch
    applyStimulus(kLd, 12'h200, 3'd0);
    applyStimulus(kLd | kInc | kSkip | kLatch, 12'h050, 3'd0);
    checkOutput("prio_pc", 32'(pcA), 32'h050);
    checkOutput("prio_pclat", 32'(pclatA), 32'h200);
    checkOutput("prio_wrap", 32'(wrapA), 32'h0);
    applyStimulus(kInc | kLatch, 12'h000, 3'd0);
    checkOutput("inclat_pc", 32'(pcA), 32'h051);
    checkOutput("inclat_pclat", 32'(pclatA), 32'h050);
    applyStimulus(kInc, 12'h000, 3'd0);
    checkOutput("pclat_hold", 32'(pclatA), 32'h050);

    // Field transfer
    applyStimulus(kLdib, 12'h000, 3'd5);
    checkOutput("ldib_ib", 32'(ibA), 32'h5);
    checkOutput("ldib_if", 32'(ifA), 32'h0);
    applyStimulus(kJmp, 12'h000, 3'd0);
    checkOutput("jmp_alone_if", 32'(ifA), 32'h0);
    applyStimulus(kLd | kJmp, 12'h400, 3'd0);
    checkOutput("ldjmp_if", 32'(ifA), 32'h5);
    checkOutput("ldjmp_pc", 32'(pcA), 32'h400);
    checkOutput("ldjmp_addr", 32'(addrA), 32'h5400);

    // Interrupt and restore
    applyStimulus(kIntr | kLdib, 12'h000, 3'd3);
    checkOutput("intr_sf", 32'(sfA), 32'h5);
    checkOutput("intr_if", 32'(ifA), 32'h0);
    checkOutput("intr_ib", 32'(ibA), 32'h0);
    checkOutput("intr_pc", 32'(pcA), 32'h400);
    applyStimulus(kRestore, 12'h000, 3'd0);
    checkOutput("restore_ib", 32'(ibA), 32'h5);
    checkOutput("restore_sf", 32'(sfA), 32'h5);
    applyStimulus(kLdib | kRestore, 12'h000, 3'd2);
    checkOutput("ldib_beats_restore", 32'(ibA), 32'h2);
    applyStimulus(kRestore, 12'h000, 3'd0);
    applyStimulus(kLd | kJmp | kLdib, 12'h010, 3'd6);
    checkOutput("jmp_ldib_if", 32'(ifA), 32'h5);
    checkOutput("jmp_ldib_ib", 32'(ibA), 32'h6);
    checkOutput("jmp_ldib_addr", 32'(addrA), 32'h5010);
    applyStimulus(kClr | kIntr | kLd | kInc | kLatch, 12'h777, 3'd7);
    checkOutput("clr_pc", 32'(pcA), 32'h000);
    checkOutput("clr_pclat", 32'(pclatA), 32'h000);
    checkOutput("clr_fields", {23'd0, ifA, ibA, sfA}, 32'h0);

    // Parameter sweep instance
    applyStimulusB(kClr, 15'h0000, 2'd0);
    checkOutput("b_rst_pc", 32'(pcB), 32'h7FF0);
    checkOutput("b_rst_wrap", 32'(wrapB), 32'h0);
    wrapPulses = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulusB(kInc, 15'h0000, 2'd0);
      if (wrapB) wrapPulses++;
    end
    checkOutput("b_inc16_pc", 32'(pcB), 32'h0000);
    checkOutput("b_inc16_wrap", 32'(wrapB), 32'h1);
    applyStimulusB(kIdle, 15'h0000, 2'd0);
    checkOutput("b_wrap_pulses", 32'(wrapPulses), 32'd1);
    checkOutput("b_wrap_drop", 32'(wrapB), 32'h0);
    applyStimulusB(kLdib, 15'h0000, 2'd3);
    applyStimulusB(kLd | kJmp, 15'h1234, 2'd0);
    checkOutput("b_addr", 32'(addrB), 32'h19234);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
